// File: rtl/multi_region_tracker_if.sv
// Pixel-stream input and per-frame statistics output bundle for multi_region_tracker.
interface multi_region_tracker_if #(
  parameter int N_REGIONS = 4
);
  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  logic                 pix_valid;
  logic [9:0]           pix_x;
  logic                 pix_hit;
  logic                 frame_end;
  logic [N_REGIONS-1:0] region_active;
  logic [IDX_W-1:0]     winner_idx;
  logic                 winner_valid;
  logic [9:0]           centroid_x;
  logic                 centroid_valid;
  logic                 stats_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output pix_valid, pix_x, pix_hit, frame_end,
    input  region_active, winner_idx, winner_valid, centroid_x, centroid_valid,
           stats_valid, busy, overrun
  );
  modport slave (
    input  pix_valid, pix_x, pix_hit, frame_end,
    output region_active, winner_idx, winner_valid, centroid_x, centroid_valid,
           stats_valid, busy, overrun
  );
endinterface

// File: rtl/multi_region_tracker.sv
// Per-strip colour-hit counting with frame snapshot, serial centroid divider,
// winner selection and per-strip hysteresis on detection.
module region_lane #(
  parameter int CNT_W       = 17,
  parameter int THRESH      = 400,
  parameter int HOLD_FRAMES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             snap,
  input  logic             take,
  input  logic             upd,
  output logic [CNT_W-1:0] shadow_cnt,
  output logic             active
);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic [CNT_W-1:0] live, live_inc;
  logic [HW-1:0]    hold;
  logic             det;

  assign live_inc = (hit && !(&live)) ? live + 1'b1 : live;
  assign det      = shadow_cnt >= CNT_W'(THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      live       <= '0;
      shadow_cnt <= '0;
      hold       <= '0;
      active     <= 1'b0;
    end else begin
      live <= snap ? '0 : live_inc;
      if (take) shadow_cnt <= live_inc;
      // Disagreeing frames accumulate; one agreeing frame resets the run.
      if (upd) begin
        if (det != active) begin
          if (hold == HW'(HOLD_FRAMES - 1)) begin
            active <= ~active;
            hold   <= '0;
          end else begin
            hold <= hold + 1'b1;
          end
        end else begin
          hold <= '0;
        end
      end
    end
  end
endmodule

module multi_region_tracker #(
  parameter int H_RES       = 640,
  parameter int N_REGIONS   = 4,
  parameter int CNT_W       = 17,
  parameter int SUM_W       = 28,
  parameter int THRESH      = 400,
  parameter int HOLD_FRAMES = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  multi_region_tracker_if.slave    bus
);
  localparam int STRIP_W = H_RES / N_REGIONS;
  localparam int IDX_W   = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int STEP_W  = $clog2(SUM_W + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, UPDATE} state_t;
  state_t state, state_nxt;

  logic                 hit_ok, snap, take, upd;
  logic [31:0]          px;
  logic [N_REGIONS-1:0] strip_hit, act;
  logic [N_REGIONS-1:0][CNT_W-1:0] shadow_cnt;

  logic [CNT_W-1:0] tot, tot_inc, shadow_tot;
  logic [SUM_W-1:0] sum, sum_inc, shadow_sum;
  logic [SUM_W:0]   sum_add;

  logic [SUM_W-1:0] quo;
  logic [CNT_W-1:0] rem;
  logic [CNT_W:0]   rem_sh, rem_diff;
  logic             rem_ge;
  logic [STEP_W-1:0] step;

  logic [IDX_W-1:0] win_idx, win_idx_q;
  logic             win_vld, win_vld_q;
  logic [CNT_W-1:0] win_cnt;
  logic [9:0]       cent_q;
  logic             cent_vld_q, stats_q, overrun_q;

  assign px     = {22'd0, bus.pix_x};
  assign hit_ok = bus.pix_valid && bus.pix_hit && (px < 32'(H_RES));
  assign snap   = bus.frame_end;
  assign take   = bus.frame_end && (state == IDLE);
  assign upd    = (state == UPDATE);

  // Strip select by range compare; each lane sees only its own hits.
  for (genvar i = 0; i < N_REGIONS; i++) begin : g_lane
    assign strip_hit[i] = hit_ok && (px >= 32'(i * STRIP_W)) && (px < 32'((i + 1) * STRIP_W));
    region_lane #(.CNT_W(CNT_W), .THRESH(THRESH), .HOLD_FRAMES(HOLD_FRAMES)) u_lane (
      .clk(clk), .rst(rst), .hit(strip_hit[i]), .snap(snap), .take(take), .upd(upd),
      .shadow_cnt(shadow_cnt[i]), .active(act[i])
    );
  end

  assign tot_inc = (hit_ok && !(&tot)) ? tot + 1'b1 : tot;
  assign sum_add = {1'b0, sum} + (SUM_W + 1)'(bus.pix_x);
  assign sum_inc = !hit_ok ? sum : (sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0]);

  // Restoring divider: one quotient bit per DIVIDE cycle, MSB first.
  assign rem_sh   = {rem, quo[SUM_W-1]};
  assign rem_ge   = rem_sh >= {1'b0, shadow_tot};
  assign rem_diff = rem_sh - {1'b0, shadow_tot};

  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_cnt = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (shadow_cnt[i] >= CNT_W'(THRESH) && (!win_vld || shadow_cnt[i] > win_cnt)) begin
        win_idx = IDX_W'(i);
        win_vld = 1'b1;
        win_cnt = shadow_cnt[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.frame_end) state_nxt = DIVIDE;
      DIVIDE:  if (step == STEP_W'(SUM_W - 1)) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tot        <= '0;
      sum        <= '0;
      shadow_tot <= '0;
      shadow_sum <= '0;
      quo        <= '0;
      rem        <= '0;
      step       <= '0;
      win_idx_q  <= '0;
      win_vld_q  <= 1'b0;
      cent_q     <= '0;
      cent_vld_q <= 1'b0;
      stats_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tot     <= snap ? '0 : tot_inc;
      sum     <= snap ? '0 : sum_inc;
      stats_q <= 1'b0;
      if (snap && state != IDLE) overrun_q <= 1'b1;
      if (take) begin
        shadow_tot <= tot_inc;
        shadow_sum <= sum_inc;
        quo        <= sum_inc;
        rem        <= '0;
        step       <= '0;
      end
      if (state == DIVIDE) begin
        rem  <= rem_ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
        quo  <= {quo[SUM_W-2:0], rem_ge};
        step <= step + 1'b1;
      end
      if (upd) begin
        stats_q    <= 1'b1;
        win_idx_q  <= win_idx;
        win_vld_q  <= win_vld;
        cent_vld_q <= (shadow_tot != '0);
        if (shadow_tot != '0) cent_q <= quo[9:0];
      end
    end
  end

  assign bus.region_active  = act;
  assign bus.winner_idx     = win_idx_q;
  assign bus.winner_valid   = win_vld_q;
  assign bus.centroid_x     = cent_q;
  assign bus.centroid_valid = cent_vld_q;
  assign bus.stats_valid    = stats_q;
  assign bus.busy           = (state != IDLE);
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_multi_region_tracker.sv
// Directed bench for multi_region_tracker with default parameters (SUM_W=28 -> 30-cycle latency).
module tb_multi_region_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lat;
  int   pulses;

  always #5 clk = ~clk;

  multi_region_tracker_if #(.N_REGIONS(4)) bus();
  multi_region_tracker dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_hits(input int x, input int n, input logic vld);
    for (int i = 0; i < n; i++) begin
      bus.pix_valid = vld;
      bus.pix_hit   = 1'b1;
      bus.pix_x     = 10'(x);
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
  endtask

  // Waits for stats_valid; lat counts cycles since the frame_end cycle.
  task automatic wait_stats(input int start, output int l);
    l = start;
    while (bus.stats_valid !== 1'b1 && l < 80) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic close_frame(input logic hit, input int x, output int l);
    bus.frame_end = 1'b1;
    bus.pix_valid = hit;
    bus.pix_hit   = hit;
    bus.pix_x     = 10'(x);
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    chk("busy_in_divide", 32'(bus.busy), 32'd1);
    wait_stats(1, l);
  endtask

  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.stats_valid === 1'b1) p++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_hit   = 1'b0;
    bus.pix_x     = '0;
    bus.frame_end = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_active",   32'(bus.region_active),  32'd0);
    chk("rst_wvalid",   32'(bus.winner_valid),   32'd0);
    chk("rst_cvalid",   32'(bus.centroid_valid), 32'd0);
    chk("rst_centroid", 32'(bus.centroid_x),     32'd0);
    chk("rst_busy",     32'(bus.busy),           32'd0);
    chk("rst_overrun",  32'(bus.overrun),        32'd0);

    // 500 hits at x=100, three times: activation only after the third.
    for (int f = 0; f < 3; f++) begin
      send_hits(100, 500, 1'b1);
      close_frame(1'b0, 0, lat);
      chk("a_latency",  32'(lat),                 32'd30);
      chk("a_centroid", 32'(bus.centroid_x),      32'd100);
      chk("a_cvalid",   32'(bus.centroid_valid),  32'd1);
      chk("a_winner",   32'(bus.winner_idx),      32'd0);
      chk("a_wvalid",   32'(bus.winner_valid),    32'd1);
      chk("a_active",   32'(bus.region_active),   (f == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
      chk("a_pulse_end", 32'(bus.stats_valid),    32'd0);
      chk("a_idle",      32'(bus.busy),           32'd0);
    end

    // Three empty frames: deactivation only after the third.
    for (int f = 0; f < 3; f++) begin
      close_frame(1'b0, 0, lat);
      chk("e_latency",  32'(lat),                 32'd30);
      chk("e_cvalid",   32'(bus.centroid_valid),  32'd0);
      chk("e_centroid", 32'(bus.centroid_x),      32'd100);
      chk("e_wvalid",   32'(bus.winner_valid),    32'd0);
      chk("e_active",   32'(bus.region_active),   (f == 2) ? 32'd0 : 32'd1);
      @(negedge clk);
    end

    // Tie between strips 1 and 3; off-screen and unqualified hits must be ignored.
    send_hits(200, 450, 1'b1);
    send_hits(700, 20, 1'b1);
    send_hits(0, 20, 1'b0);
    send_hits(600, 450, 1'b1);
    close_frame(1'b0, 0, lat);
    chk("t_latency",  32'(lat),                32'd30);
    chk("t_winner",   32'(bus.winner_idx),     32'd1);
    chk("t_wvalid",   32'(bus.winner_valid),   32'd1);
    chk("t_centroid", 32'(bus.centroid_x),     32'd400);
    chk("t_active",   32'(bus.region_active),  32'd0);
    @(negedge clk);

    close_frame(1'b0, 0, lat);
    chk("z_cvalid",   32'(bus.centroid_valid), 32'd0);
    chk("z_centroid", 32'(bus.centroid_x),     32'd400);
    chk("z_wvalid",   32'(bus.winner_valid),   32'd0);
    chk("z_winner",   32'(bus.winner_idx),     32'd0);
    @(negedge clk);

    // Single hit coincident with frame_end belongs to the closing frame.
    close_frame(1'b1, 37, lat);
    chk("c_centroid", 32'(bus.centroid_x),     32'd37);
    chk("c_cvalid",   32'(bus.centroid_valid), 32'd1);
    chk("c_wvalid",   32'(bus.winner_valid),   32'd0);
    @(negedge clk);

    // Overrun: second frame_end 10 cycles after the first is discarded.
    send_hits(100, 500, 1'b1);
    bus.frame_end = 1'b1;
    @(negedge clk);
    bus.frame_end = 1'b0;
    send_hits(500, 9, 1'b1);
    bus.frame_end = 1'b1;
    @(negedge clk);
    bus.frame_end = 1'b0;
    wait_stats(11, lat);
    chk("o_latency",  32'(lat),                32'd30);
    chk("o_overrun",  32'(bus.overrun),        32'd1);
    chk("o_centroid", 32'(bus.centroid_x),     32'd100);
    chk("o_winner",   32'(bus.winner_idx),     32'd0);
    chk("o_wvalid",   32'(bus.winner_valid),   32'd1);
    chk("o_active",   32'(bus.region_active),  32'd0);
    count_pulses(40, pulses);
    chk("o_no_second_stats", 32'(pulses), 32'd0);

    // Hysteresis advanced once by the overrun sequence: two more frames toggle strip 0.
    for (int f = 0; f < 2; f++) begin
      send_hits(100, 500, 1'b1);
      close_frame(1'b0, 0, lat);
      chk("h_active",  32'(bus.region_active), (f == 1) ? 32'd1 : 32'd0);
      chk("h_overrun", 32'(bus.overrun),       32'd1);
      @(negedge clk);
    end

    // Reset 5 cycles into DIVIDE aborts the frame.
    send_hits(100, 500, 1'b1);
    bus.frame_end = 1'b1;
    @(negedge clk);
    bus.frame_end = 1'b0;
    repeat (4) @(negedge clk);
    chk("r_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("r_active",   32'(bus.region_active),  32'd0);
    chk("r_wvalid",   32'(bus.winner_valid),   32'd0);
    chk("r_winner",   32'(bus.winner_idx),     32'd0);
    chk("r_centroid", 32'(bus.centroid_x),     32'd0);
    chk("r_cvalid",   32'(bus.centroid_valid), 32'd0);
    chk("r_busy",     32'(bus.busy),           32'd0);
    chk("r_overrun",  32'(bus.overrun),        32'd0);
    count_pulses(40, pulses);
    chk("r_no_stats", 32'(pulses), 32'd0);

    send_hits(300, 500, 1'b1);
    close_frame(1'b0, 0, lat);
    chk("n_latency",  32'(lat),                32'd30);
    chk("n_centroid", 32'(bus.centroid_x),     32'd300);
    chk("n_winner",   32'(bus.winner_idx),     32'd1);
    chk("n_wvalid",   32'(bus.winner_valid),   32'd1);
    chk("n_active",   32'(bus.region_active),  32'd0);
    chk("n_overrun",  32'(bus.overrun),        32'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
